key_filter_dual: RTL and testbench
==================================

KEY_FILTER_DUAL -- requirements
Module: key_filter_dual

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 1000000, sets the consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 Parameter KEY_ACTIVE_LOW, default 1, selects the pressed level: 1 means a pressed key reads 0, 0 means a pressed key reads 1.
REQ-003 Port clk, input, 1 bit: single system clock, rising-edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port key_in1, input, 1 bit: raw, asynchronous, bouncing key 1 (forward command).
REQ-006 Port key_in2, input, 1 bit: raw, asynchronous, bouncing key 2 (reverse command).
REQ-007 Port key_state1, output, 1 bit: registered level, 1 while key 1 is debounced-held and owns the motor command.
REQ-008 Port key_state2, output, 1 bit: registered level, 1 while key 2 is debounced-held and owns the motor command.
REQ-009 Port key_flag1, output, 1 bit: one-cycle pulse on the cycle key_state1 rises.
REQ-010 Port key_flag2, output, 1 bit: one-cycle pulse on the cycle key_state2 rises.

Function
REQ-011 Each key_in shall pass through a 2-flop synchronizer and then be normalised so that pressed=1 internally, per KEY_ACTIVE_LOW.
REQ-012 Each key shall have its own filter FSM with states IDLE (released), PRESS_CHK, HELD and REL_CHK, plus a counter of width ceil(log2(DEBOUNCE_CNT)).
REQ-013 In IDLE, a pressed sample shall move the FSM to PRESS_CHK with the counter cleared to 0.
REQ-014 In PRESS_CHK, each pressed sample shall increment the counter; at counter==DEBOUNCE_CNT-1 with the sample still pressed, the FSM shall go to HELD and clear the counter.
REQ-015 In PRESS_CHK, any released sample shall return the FSM to IDLE and clear the counter (bounce restarts the filter).
REQ-016 HELD to REL_CHK to IDLE shall mirror REQ-013..015, with released samples counting and a pressed sample returning the FSM to HELD.
REQ-017 The counter shall never wrap; it is cleared on every state transition and held at 0 in IDLE and HELD.
REQ-018 Ownership register owner ∈ {NONE, K1, K2}.
REQ-019 From NONE, owner becomes K1 if filter 1 is HELD; otherwise it becomes K2 if filter 2 is HELD; K1 wins when both reach HELD on the same cycle.
REQ-020 From K1 or K2, owner returns to NONE when the owning filter leaves the HELD/REL_CHK pair (reaches IDLE); the non-owning key is ignored while owned.
REQ-021 A non-owning key still HELD when owner returns to NONE shall be granted on the next cycle (no re-press needed).
REQ-022 key_state1 = (owner==K1) and key_state2 = (owner==K2), registered; the two outputs shall never be 1 simultaneously.
REQ-023 key_flagN shall be 1 for exactly one cycle, the first cycle key_stateN is 1, and 0 otherwise.
REQ-024 Latency from a clean press edge on key_inN to key_stateN=1 shall be 2 (sync) + DEBOUNCE_CNT + 1 (owner) cycles, ±1 for input sampling phase; release latency shall be the same.

Reset
REQ-025 While rst=1, all outputs shall be 0, both FSMs shall be IDLE, counters 0, owner NONE, and synchronizer flops at the released level (1 if KEY_ACTIVE_LOW=1).
REQ-026 On rst deassertion mid-press, the filter shall restart from IDLE, and a held key shall require a full DEBOUNCE_CNT qualification before key_state rises.
REQ-027 Reset asserted while key_state is 1 shall drop key_state and key_flag to 0 immediately (asynchronously).

Verification (DEBOUNCE_CNT=8, KEY_ACTIVE_LOW=1)
REQ-028 Clean press: key_in1 driven to 0 and held -> key_state1=1 and key_flag1=1 for one cycle, 11 cycles after the edge (±1); key_state2 stays 0.
REQ-029 Bounce: key_in1 toggles 0/1 every 3 cycles for 30 cycles, then held at 0 -> no key_state1 during bouncing; rise 11 cycles (±1) after the final stable edge.
REQ-030 Release bounce: release key_in1 with a 2-cycle glitch back to 0 at release+4 -> key_state1 falls 11 cycles (±1) after the glitch ends, not before.
REQ-031 Simultaneous: key_in1 and key_in2 pressed on the same cycle -> key_state1=1 and key_state2=0; release key_in1 with key 2 held -> key_state1 falls, key_state2 rises 1 cycle later, and key_flag2 pulses once.
REQ-032 Reset mid-operation: key_state2=1, then pulse rst for 3 cycles with key_in2 held at 0 -> outputs 0 during reset; key_state2 returns 11 cycles (±1) after rst falls.

Source files
------------

// File: rtl/key_filter_dual.sv
// Dual-key debouncer with mutually exclusive ownership of a motor command.
// Each key is synchronised, debounced by its own FSM, and the first key held wins the output.
module key_filter_dual #(
  parameter int unsigned DEBOUNCE_CNT   = 1000000,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in1,
  input  logic key_in2,
  output logic key_state1,
  output logic key_state2,
  output logic key_flag1,
  output logic key_flag2
);

  localparam int unsigned     CntW   = $clog2(DEBOUNCE_CNT);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CNT - 1);
  localparam logic [1:0]      RelLvl = {2{KEY_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    StIdle,
    StPressChk,
    StHeld,
    StRelChk
  } filt_st_e;

  typedef enum logic [1:0] {
    OwnNone = 2'b00,
    OwnK1   = 2'b01,
    OwnK2   = 2'b10
  } owner_e;

  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      pressed;
  filt_st_e        st_q  [2];
  logic [CntW-1:0] cnt_q [2];
  logic [1:0]      held, active;
  owner_e          owner_q, owner_d;
  logic [1:0]      state_q, flag_q;

  // Synchronisers idle at the released level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RelLvl;
      sync2_q <= RelLvl;
    end else begin
      sync1_q <= {key_in2, key_in1};
      sync2_q <= sync1_q;
    end
  end

  assign pressed = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= StIdle;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        unique case (st_q[i])
          StIdle: begin
            cnt_q[i] <= '0;
            if (pressed[i]) st_q[i] <= StPressChk;
          end
          StPressChk: begin
            if (!pressed[i]) begin
              st_q[i]  <= StIdle;
              cnt_q[i] <= '0;
            end else if (cnt_q[i] == CntMax) begin
              st_q[i]  <= StHeld;
              cnt_q[i] <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + CntW'(1);
            end
          end
          StHeld: begin
            cnt_q[i] <= '0;
            if (!pressed[i]) st_q[i] <= StRelChk;
          end
          StRelChk: begin
            if (pressed[i]) begin
              st_q[i]  <= StHeld;
              cnt_q[i] <= '0;
            end else if (cnt_q[i] == CntMax) begin
              st_q[i]  <= StIdle;
              cnt_q[i] <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + CntW'(1);
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    held   = '0;
    active = '0;
    for (int i = 0; i < 2; i++) begin
      held[i]   = (st_q[i] == StHeld);
      active[i] = (st_q[i] == StHeld) || (st_q[i] == StRelChk);
    end
  end

  // Key 1 has priority on a tie; a still-held loser is picked up once the owner lets go.
  always_comb begin
    owner_d = owner_q;
    case (owner_q)
      OwnNone: begin
        if (held[0])      owner_d = OwnK1;
        else if (held[1]) owner_d = OwnK2;
      end
      OwnK1:   if (!active[0]) owner_d = OwnNone;
      OwnK2:   if (!active[1]) owner_d = OwnNone;
      default: owner_d = OwnNone;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OwnNone;
      state_q <= '0;
      flag_q  <= '0;
    end else begin
      owner_q <= owner_d;
      state_q <= {owner_d == OwnK2, owner_d == OwnK1};
      flag_q  <= {(owner_d == OwnK2) && (owner_q != OwnK2),
                  (owner_d == OwnK1) && (owner_q != OwnK1)};
    end
  end

  assign key_state1 = state_q[0];
  assign key_state2 = state_q[1];
  assign key_flag1  = flag_q[0];
  assign key_flag2  = flag_q[1];

endmodule

// File: tb/tb_key_filter_dual.sv
// Scoreboard bench for key_filter_dual: stimulus queues expected output edges with cycle
// windows, an independent monitor pops and checks them as the outputs change.
module tb_key_filter_dual;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_in1 = 1'b1;
  logic key_in2 = 1'b1;
  logic key_state1, key_state2, key_flag1, key_flag2;

  key_filter_dual #(
    .DEBOUNCE_CNT  (8),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in1   (key_in1),
    .key_in2   (key_in2),
    .key_state1(key_state1),
    .key_state2(key_state2),
    .key_flag1 (key_flag1),
    .key_flag2 (key_flag2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 state1 rise, 1 state1 fall, 2 state2 rise, 3 state2 fall
  typedef struct {
    int kind;
    int lo;
    int hi;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic p1 = 1'b0;
  logic p2 = 1'b0;

  function automatic string kname(input int k);
    case (k)
      0:       return "key_state1 rise";
      1:       return "key_state1 fall";
      2:       return "key_state2 rise";
      default: return "key_state2 fall";
    endcase
  endfunction

  task automatic expect_ev(input int kind, input int lo, input int hi);
    exp_t e;
    e.kind = kind;
    e.lo   = lo;
    e.hi   = hi;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int kind, input int at);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got %s at cycle %0d, want no event", kname(kind), at);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || at < e.lo || at > e.hi) begin
        errors++;
        $display("FAIL event: got %s at cycle %0d, want %s in [%0d,%0d]",
                 kname(kind), at, kname(e.kind), e.lo, e.hi);
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        checks++;
        if ({key_state1, key_state2, key_flag1, key_flag2} != 4'b0000) begin
          errors++;
          $display("FAIL reset_outputs: got %b, want 0000 at cycle %0d",
                   {key_state1, key_state2, key_flag1, key_flag2}, cyc);
        end
      end
      checks++;
      if (key_state1 && key_state2) begin
        errors++;
        $display("FAIL exclusive: got both key_state high, want at most one at cycle %0d", cyc);
      end
      if ((key_state1 && !p1) || key_flag1) begin
        checks++;
        if (key_flag1 != (key_state1 && !p1)) begin
          errors++;
          $display("FAIL flag1: got %b, want %b at cycle %0d", key_flag1, key_state1 && !p1, cyc);
        end
      end
      if ((key_state2 && !p2) || key_flag2) begin
        checks++;
        if (key_flag2 != (key_state2 && !p2)) begin
          errors++;
          $display("FAIL flag2: got %b, want %b at cycle %0d", key_flag2, key_state2 && !p2, cyc);
        end
      end
      if (key_state1 != p1) got_ev(key_state1 ? 0 : 1, cyc);
      if (key_state2 != p2) got_ev(key_state2 ? 2 : 3, cyc);
      p1 = key_state1;
      p2 = key_state2;
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc_wait(3);
    rst = 1'b0;
    cyc_wait(5);

    // Clean press and release of key 1
    key_in1 = 1'b0;
    expect_ev(0, cyc + 11, cyc + 12);
    cyc_wait(20);
    key_in1 = 1'b1;
    expect_ev(1, cyc + 11, cyc + 12);
    cyc_wait(20);

    // Press bounce: toggle every 3 cycles for 30 cycles, then hold pressed
    for (int i = 0; i < 10; i++) begin
      key_in1 = (i % 2 == 1) ? 1'b1 : 1'b0;
      cyc_wait(3);
    end
    key_in1 = 1'b0;
    expect_ev(0, cyc + 11, cyc + 12);
    cyc_wait(20);

    // Release with a 2-cycle glitch back to pressed at release+4
    key_in1 = 1'b1;
    cyc_wait(4);
    key_in1 = 1'b0;
    cyc_wait(2);
    key_in1 = 1'b1;
    expect_ev(1, cyc + 11, cyc + 12);
    cyc_wait(20);

    // Simultaneous press: key 1 wins, key 2 granted after key 1 releases
    key_in1 = 1'b0;
    key_in2 = 1'b0;
    expect_ev(0, cyc + 11, cyc + 12);
    cyc_wait(20);
    key_in1 = 1'b1;
    expect_ev(1, cyc + 11, cyc + 12);
    expect_ev(2, cyc + 12, cyc + 13);
    cyc_wait(20);

    // Asynchronous reset while key_state2 is high, key 2 kept pressed
    #2;
    rst = 1'b1;
    expect_ev(3, cyc + 1, cyc + 1);
    #1;
    checks++;
    if ({key_state1, key_state2, key_flag1, key_flag2} != 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got %b, want 0000",
               {key_state1, key_state2, key_flag1, key_flag2});
    end
    cyc_wait(3);
    rst = 1'b0;
    expect_ev(2, cyc + 11, cyc + 12);
    cyc_wait(20);
    key_in2 = 1'b1;
    expect_ev(3, cyc + 11, cyc + 12);
    cyc_wait(20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d unmatched expected events, want 0 (next %s)",
               exp_q.size(), kname(exp_q[0].kind));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
